alu_cmd_sequencer: RTL and testbench

- Initiator side of the ALU interface. Accepts operation commands over a valid/ready handshake and fetches operands from an internal register file.
- Drives opcode, A, B and carry-in into the combinational ALU (module_ALU), captures result, carry-out and zero flag, writes the result back, and returns a response over a second valid/ready handshake.
- Sits between the lab's command source (testbench, or FPGA switches/UART front-end) and the ALU.

---
 rtl/alu_seq_pkg.sv | 51 +++++
 rtl/alu_seq_regfile.sv | 40 ++++
 rtl/alu_cmd_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: state type, opcode constants and decode helpers shared by the
// alu_cmd_sequencer files.
// Build option: define ALU_SEQ_LOADIMM_EN to make opcode 0xF a load-immediate.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_PASS = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_NAND = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hF;

`ifdef ALU_SEQ_LOADIMM_EN
  localparam bit LDI_EN = 1'b1;
`else
  localparam bit LDI_EN = 1'b0;
`endif

  // Ops for which the ALU drives a meaningful carry-out.
  function automatic logic carry_updates(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SHL, OP_SHR: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic is_ldi(input logic [3:0] op);
    return LDI_EN && (op == OP_LDI);
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_XOR, OP_NOT,
      OP_PASS, OP_SUB, OP_NAND, OP_SHL, OP_SHR: return 1'b1;
      OP_LDI:                                   return LDI_EN;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NREG x N register file, two asynchronous read ports,
// one synchronous write port, cleared by asynchronous active-low reset.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned NREG = 4,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_addr,
  output logic [N-1:0]  ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [N-1:0]  rb_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [N-1:0]  wd
);

  logic [N-1:0] mem [NREG];

  // Storage: cleared on reset, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  // Asynchronous read ports.
  always_comb begin
    ra_data = mem[ra_addr];
    rb_data = mem[rb_addr];
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts ALU commands, fetches operands from the local
// register file, drives the external combinational ALU for one cycle, writes
// the result back and returns a response.
// Build option: define ALU_SEQ_LOADIMM_EN to enable opcode 0xF load-immediate.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned NREG = 4,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [3:0]    cmd_op_i,
  input  logic [AW-1:0] cmd_rd_i,
  input  logic [AW-1:0] cmd_rs1_i,
  input  logic [AW-1:0] cmd_rs2_i,
  input  logic          cmd_usec_i,
  input  logic          cmd_flagin_i,
  input  logic [N-1:0]  cmd_imm_i,
  output logic [N-1:0]  alu_a_o,
  output logic [N-1:0]  alu_b_o,
  output logic [3:0]    alu_cont_o,
  output logic          alu_flagin_o,
  input  logic [N-1:0]  alu_result_i,
  input  logic          alu_flagout_i,
  input  logic          alu_flagz_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [N-1:0]  rsp_result_o,
  output logic          rsp_carry_o,
  output logic          rsp_zero_o,
  output logic          rsp_err_o
);

  state_t        state;
  logic [3:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [N-1:0]  imm_q;
  logic          legal_q;
  logic          ldi_q;
  logic          carry_q;
  logic          zero_q;

  logic [N-1:0]  rs1_data;
  logic [N-1:0]  rs2_data;
  logic          wr_en;
  logic [N-1:0]  wr_data;
  logic          carry_next;
  logic          zero_next;

  alu_seq_regfile #(
    .N    (N),
    .NREG (NREG)
  ) u_regfile (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .ra_addr (cmd_rs1_i),
    .ra_data (rs1_data),
    .rb_addr (cmd_rs2_i),
    .rb_data (rs2_data),
    .we      (wr_en),
    .wa      (rd_q),
    .wd      (wr_data)
  );

  // Write-back and next-flag values, used only at the end of ISSUE.
  always_comb begin
    wr_en      = (state == ISSUE) && legal_q;
    wr_data    = ldi_q ? imm_q : alu_result_i;
    carry_next = (!ldi_q && carry_updates(op_q)) ? alu_flagout_i : carry_q;
    zero_next  = ldi_q ? (imm_q == '0) : alu_flagz_i;
  end

  // Control FSM with registered handshake, ALU and response outputs.
  // The carry-in select is resolved at accept time: carry_q cannot change
  // between accept and ISSUE, so this equals selecting during ISSUE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      op_q         <= '0;
      rd_q         <= '0;
      imm_q        <= '0;
      legal_q      <= 1'b0;
      ldi_q        <= 1'b0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      cmd_ready_o  <= 1'b0;
      alu_a_o      <= '0;
      alu_b_o      <= '0;
      alu_cont_o   <= '0;
      alu_flagin_o <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_result_o <= '0;
      rsp_carry_o  <= 1'b0;
      rsp_zero_o   <= 1'b0;
      rsp_err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            op_q         <= cmd_op_i;
            rd_q         <= cmd_rd_i;
            imm_q        <= cmd_imm_i;
            legal_q      <= op_legal(cmd_op_i);
            ldi_q        <= is_ldi(cmd_op_i);
            alu_a_o      <= rs1_data;
            alu_b_o      <= rs2_data;
            alu_cont_o   <= (op_legal(cmd_op_i) && !is_ldi(cmd_op_i)) ? cmd_op_i : OP_AND;
            alu_flagin_o <= cmd_usec_i ? carry_q : cmd_flagin_i;
            cmd_ready_o  <= 1'b0;
            state        <= ISSUE;
          end else begin
            cmd_ready_o  <= 1'b1;
          end
        end
        ISSUE: begin
          rsp_valid_o <= 1'b1;
          state       <= RESP;
          if (legal_q) begin
            carry_q      <= carry_next;
            zero_q       <= zero_next;
            rsp_result_o <= wr_data;
            rsp_carry_o  <= carry_next;
            rsp_zero_o   <= zero_next;
            rsp_err_o    <= 1'b0;
          end else begin
            rsp_result_o <= '0;
            rsp_carry_o  <= carry_q;
            rsp_zero_o   <= zero_q;
            rsp_err_o    <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: behavioural ALU, reference model of the
// register file and flags, scoreboard queue checked by a response monitor.
module tb_alu_cmd_sequencer;

  localparam int N    = 4;
  localparam int NREG = 4;
  localparam int AW   = 2;

`ifdef ALU_SEQ_LOADIMM_EN
  localparam bit TB_LDI = 1'b1;
`else
  localparam bit TB_LDI = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = '0;
  logic [AW-1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic          cmd_usec = 1'b0, cmd_flagin = 1'b0;
  logic [N-1:0]  cmd_imm = '0;
  logic [N-1:0]  alu_a, alu_b, alu_result;
  logic [3:0]    alu_cont;
  logic          alu_flagin, alu_flagout, alu_flagz;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [N-1:0]  rsp_result;
  logic          rsp_carry, rsp_zero, rsp_err;

  alu_cmd_sequencer #(.N(N), .NREG(NREG)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_op_i      (cmd_op),
    .cmd_rd_i      (cmd_rd),
    .cmd_rs1_i     (cmd_rs1),
    .cmd_rs2_i     (cmd_rs2),
    .cmd_usec_i    (cmd_usec),
    .cmd_flagin_i  (cmd_flagin),
    .cmd_imm_i     (cmd_imm),
    .alu_a_o       (alu_a),
    .alu_b_o       (alu_b),
    .alu_cont_o    (alu_cont),
    .alu_flagin_o  (alu_flagin),
    .alu_result_i  (alu_result),
    .alu_flagout_i (alu_flagout),
    .alu_flagz_i   (alu_flagz),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_result_o  (rsp_result),
    .rsp_carry_o   (rsp_carry),
    .rsp_zero_o    (rsp_zero),
    .rsp_err_o     (rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  // Behavioural ALU: {carry-out, result}. Ops without a defined carry-out
  // return 1 there so a wrongly captured carry is visible.
  function automatic logic [N:0] alu_fn(input logic [3:0] op, input logic [N-1:0] a,
                                        input logic [N-1:0] b, input logic cin);
    logic [N:0] t;
    case (op)
      4'h0:    t = {a[N-1] & b[N-1], a & b};
      4'h1:    t = {a[N-1] | b[N-1], a | b};
      4'h2:    t = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
      4'h3:    t = {1'b1, a ^ b};
      4'h4:    t = {1'b1, ~a};
      4'h5:    t = {1'b1, b};
      4'h6:    t = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, cin};
      4'h7:    t = {1'b1, ~(a & b)};
      4'h8:    t = {a[N-1], a[N-2:0], cin};
      4'h9:    t = {a[0], cin, a[N-1:1]};
      default: t = {1'b1, a ^ ~b};
    endcase
    return t;
  endfunction

  always_comb begin
    {alu_flagout, alu_result} = alu_fn(alu_cont, alu_a, alu_b, alu_flagin);
    alu_flagz = (alu_result == '0);
  end

  // Reference model state and scoreboard.
  logic [N-1:0] ref_reg [NREG];
  logic         ref_c, ref_z;
  logic [N+2:0] exp_q [$];   // {result, carry, zero, err}
  int           issue_q [$];
  logic [N+2:0] last_rsp = '0;
  int           last_xfer_cyc = 0;
  int           last_issue_cyc = 0;
  int           rdy_mode = 0;  // 0 always ready, 1 random, 2 held low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) ref_reg[i] = '0;
    ref_c = 1'b0;
    ref_z = 1'b0;
    exp_q.delete();
    issue_q.delete();
  endtask

  // Consumer: ready changes just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every presented response with the scoreboard head.
  initial begin
    bit prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        continue;
      end
      if (rsp_valid) begin
        if (!prev_v) begin
          if (issue_q.size() == 0) check("rsp_latency_orphan", 1, 0);
          else check("rsp_latency", 32'(cyc), 32'(issue_q.pop_front() + 1));
        end
        check("cmd_ready_in_resp", {31'b0, cmd_ready}, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          check("rsp_fields", {rsp_result, rsp_carry, rsp_zero, rsp_err}, exp_q[0]);
          if (rsp_ready) begin
            last_rsp      = {rsp_result, rsp_carry, rsp_zero, rsp_err};
            last_xfer_cyc = cyc;
            void'(exp_q.pop_front());
          end
        end
      end
      prev_v = rsp_valid;
    end
  end

  // Driver: present a command, model it at acceptance, check ALU drive in ISSUE.
  task automatic send(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                      input logic [AW-1:0] rs2, input bit usec, input bit flagin,
                      input logic [N-1:0] imm);
    int          waited = 0;
    logic [N-1:0] a, b, r;
    logic         cin, legal;
    logic [N:0]   t;
    logic [3:0]   econt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_usec = usec; cmd_flagin = flagin; cmd_imm = imm;
    while (!cmd_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 100) begin
        check("cmd_accept_timeout", 1, 0);
        cmd_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    a     = ref_reg[rs1];
    b     = ref_reg[rs2];
    cin   = usec ? ref_c : flagin;
    legal = (op <= 4'h9) || (op == 4'hF && TB_LDI);
    econt = 4'h0;
    if (!legal) begin
      exp_q.push_back({{N{1'b0}}, ref_c, ref_z, 1'b0} | (N+3)'(1));
    end else if (op == 4'hF) begin
      ref_reg[rd] = imm;
      ref_z       = (imm == '0);
      exp_q.push_back({imm, ref_c, ref_z, 1'b0});
    end else begin
      econt = op;
      t     = alu_fn(op, a, b, cin);
      r     = t[N-1:0];
      ref_reg[rd] = r;
      ref_z       = (r == '0);
      if (op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h8, 4'h9}) ref_c = t[N];
      exp_q.push_back({r, ref_c, ref_z, 1'b0});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    last_issue_cyc = cyc;
    issue_q.push_back(cyc);
    check("issue_cont", {28'b0, alu_cont}, {28'b0, econt});
    check("issue_a", 32'(alu_a), 32'(a));
    check("issue_b", 32'(alu_b), 32'(b));
    check("issue_flagin", {31'b0, alu_flagin}, {31'b0, cin});
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  task automatic check_last(input string name, input logic [N-1:0] res, input bit c,
                            input bit z, input bit e);
    wait_done();
    check(name, 32'(last_rsp), 32'({res, c, z, e}));
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_cmd_ready", {31'b0, cmd_ready}, 0);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 0);
    check("reset_alu_out", {alu_a, alu_b, alu_cont, alu_flagin}, 0);
    check("reset_rsp_out", {rsp_result, rsp_carry, rsp_zero, rsp_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'b0, cmd_ready}, 1);

    // Build reg1 = 5, reg2 = 3 from cleared registers, then add them.
    send(4'h2, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1, '0);
    send(4'h2, 2'd2, 2'd1, 2'd1, 1'b0, 1'b1, '0);
    send(4'h2, 2'd1, 2'd2, 2'd1, 1'b0, 1'b1, '0);
    send(4'h2, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, '0);
    check_last("add_5_3", 4'd8, 1'b0, 1'b0, 1'b0);

    // Wrap to zero with carry out, then chain the carry in.
    send(4'h4, 2'd1, 2'd3, 2'd3, 1'b0, 1'b0, '0);
    send(4'h2, 2'd2, 2'd3, 2'd3, 1'b0, 1'b1, '0);
    send(4'h2, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, '0);
    check_last("add_wrap", 4'd0, 1'b1, 1'b1, 1'b0);
    send(4'h2, 2'd0, 2'd3, 2'd3, 1'b1, 1'b0, '0);
    check_last("add_carry_chain", 4'd1, 1'b0, 1'b0, 1'b0);

    // Illegal opcode: error response, nothing written.
    send(4'hB, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0, '0);
    check_last("illegal_op", 4'd0, 1'b0, 1'b0, 1'b1);
    send(4'h1, 2'd2, 2'd3, 2'd3, 1'b0, 1'b0, '0);
    check_last("reg3_untouched", 4'd0, 1'b0, 1'b1, 1'b0);

    // Back-pressure: response held, next command waits for the transfer.
    rdy_mode = 2;
    send(4'h2, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, '0);
    fork
      send(4'h3, 2'd2, 2'd1, 2'd0, 1'b0, 1'b0, '0);
      begin
        repeat (6) @(posedge clk);
        rdy_mode = 0;
      end
    join
    check("accept_after_xfer", 32'(last_issue_cyc), 32'(last_xfer_cyc + 2));
    wait_done();

    // Reset during ISSUE of a write to reg0.
    send(4'h2, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, '0);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("midop_reset_ready", {31'b0, cmd_ready}, 0);
    check("midop_reset_valid", {31'b0, rsp_valid}, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midop_ready_after", {31'b0, cmd_ready}, 1);
    repeat (3) @(negedge clk);
    check("midop_no_rsp", {31'b0, rsp_valid}, 0);
    send(4'h1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, '0);
    check_last("reg0_cleared", 4'd0, 1'b0, 1'b1, 1'b0);

    // Load-immediate of zero after a nonzero result.
    send(4'h2, 2'd3, 2'd0, 2'd0, 1'b0, 1'b1, '0);
    send(4'hF, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 4'd0);
    if (TB_LDI) check_last("ldi_zero", 4'd0, 1'b0, 1'b1, 1'b0);
    else        check_last("ldi_disabled", 4'd0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic with random consumer stalls.
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      send(4'($urandom_range(0, 15)), AW'($urandom_range(0, NREG - 1)),
           AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), N'($urandom_range(0, 15)));
    end
    rdy_mode = 0;
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
